quad_step_decoder: RTL
======================

// Module: quad_step_decoder
// PURPOSE
//  Quadrature (A/B) decoder: turns two 90-degree-phased inputs into the en/up step
//  stream that up_down_counter consumes, and keeps its own n-bit position count.
//  Sits between an external rotary/linear encoder and the counter/display path.
//  Counts 1 per edge (x4 decoding). Flags illegal double transitions.
// PARAMETERS
//  n     4  width of position output Q
//  FILT  3  stable cycles needed before a synchronized A/B change is accepted (macro only)
// PORTS
//  clk      in   1  system clock, rising edge
//  reset_n  in   1  asynchronous active-low reset
//  en       in   1  decode enable; 0 = track phase, no count/step/err
//  clr      in   1  synchronous clear of Q
//  a        in   1  encoder channel A, asynchronous
//  b        in   1  encoder channel B, asynchronous
//  Q        out  n  position count, modulo 2^n
//  step     out  1  1-cycle pulse per accepted count (drives counter en)
//  up       out  1  direction of last accepted step, 1 = up (drives counter up)
//  err      out  1  1-cycle pulse on illegal transition (A and B both change)
//  wrap     out  1  1-cycle pulse when Q wraps (2^n-1 -> 0 or 0 -> 2^n-1)
// BEHAVIOUR
//  - Reset (async, reset_n=0): Q=0, step=0, up=1, err=0, wrap=0, sync regs=00, primed=0.
//  - A/B pass a 2-FF synchronizer, always present; output ab_s.
//  - primed=0: first clock after reset release loads phase reg from ab_s, sets primed; no step/err.
//  - Phase sequence up: 00->01->11->10->00 ({a,b}); reverse order = down.
//  - Each clk with primed=1, compare ab_s with phase reg:
//      same          -> nothing
//      one-bit fwd   -> step=1, up=1, Q=Q+1
//      one-bit rev   -> step=1, up=0, Q=Q-1
//      both changed  -> err=1, Q/up unchanged, no step
//    phase reg <= ab_s in every case (resync after error).
//  - en=0: phase reg still tracks ab_s; step, err, wrap held 0; Q and up frozen.
//  - clr=1: Q<=0 that cycle, overriding any step; step/up/err still reported; wrap=0.
//  - Wrap: Q=2^n-1 with up step -> Q=0, wrap=1; Q=0 with down step -> Q=2^n-1, wrap=1.
//  - step, err, wrap registered, high exactly one cycle per event; step and err mutually exclusive.
//  - Latency: A/B edge -> Q/step update = 3 clk edges (2 sync + 1 decode), no filter.
//  - Max input rate: one phase change per 3 clk; faster input is undefined (may give err).
//  - Reset mid-operation: all state back to reset values; next count needs re-prime.
// CONFIGURATION
//  QDEC_FILTER_EN defined: ab_s passes a per-channel filter; a channel's filtered value
//    changes only after the synchronized value differs from it for FILT consecutive
//    clks. Pulses shorter than FILT clks are dropped. Latency = 3 + FILT clks.
//    Filter counters and filtered values reset to 0. Priming uses the filtered value.
//  QDEC_FILTER_EN undefined: no filter logic; decoder uses ab_s directly.
// TESTING
//  1 reset, a=b=0, en=1, 4 fwd phases (01,11,10,00), 10 clk apart -> 4 step pulses, up=1, Q=4
//  2 from Q=4, 6 reverse phases -> 6 step pulses, up=0, Q=14 (wrap=1 at 0->15)
//  3 Q=15, one fwd phase -> Q=0, wrap=1 for 1 clk, step=1 same clk
//  4 phase 00 -> 11 in one clk -> err=1 for 1 clk, Q/up unchanged; next fwd phase counts normally
//  5 en=0, 3 fwd phases, en=1 -> Q unchanged, no step; next fwd phase -> Q+1 (no err)
//  6 a=b=1 at reset release -> no err/step on priming; clr=1 with a fwd phase -> Q=0, step=1
//    (macro) 2-clk glitch on a with FILT=3 -> no step, Q unchanged

Source files
------------

// File: rtl/quad_step_decoder.sv
// quad_step_decoder
//   Quadrature (A/B) decoder with x4 decoding. Turns the two 90-degree-phased
//   encoder channels into a one-cycle step pulse plus direction, the en/up pair
//   an up_down_counter consumes. It also keeps its own n-bit position count and
//   flags illegal double transitions.
//
//   Optional build macro: QDEC_FILTER_EN
//     defined   -> each synchronized channel passes a FILT-cycle stability
//                  filter before decoding (adds FILT clocks of latency).
//     undefined -> the decoder works on the synchronized inputs directly.
//
// Parameters
//   n     width of the position count Q
//   FILT  stable cycles needed before a channel change is accepted
//         (only present when QDEC_FILTER_EN is defined)
//
// Ports
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   en       in   decode enable; 0 = phase is tracked but nothing is counted
//   clr      in   synchronous clear of Q (wins over a step in the same cycle)
//   a, b     in   encoder channels, asynchronous to clk
//   Q        out  position count, modulo 2^n
//   step     out  one-cycle pulse per accepted count
//   up       out  direction of the last accepted step, 1 = up
//   err      out  one-cycle pulse when both channels changed at once
//   wrap     out  one-cycle pulse when Q wraps in either direction

module quad_step_decoder #(
    parameter int n = 4
`ifdef QDEC_FILTER_EN
    ,
    parameter int FILT = 3
`endif
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic         clr,
    input  logic         a,
    input  logic         b,
    output logic [n-1:0] Q,
    output logic         step,
    output logic         up,
    output logic         err,
    output logic         wrap
);

    typedef enum logic {
        PRIME,
        RUN
    } state_t;

    logic [1:0] sync1;
    logic [1:0] ab_s;
    logic [1:0] dec_ab;

    // Two-flop synchronizer for both channels; {a,b} keeps A in bit 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 2'b00;
            ab_s  <= 2'b00;
        end else begin
            sync1 <= {a, b};
            ab_s  <= sync1;
        end
    end

`ifdef QDEC_FILTER_EN
    localparam int CW        = (FILT > 1) ? $clog2(FILT) : 1;
    localparam int PRIME_CYC = 3 + FILT;

    logic [1:0] ab_f;

    // Per-channel stability filter: a channel's filtered value only follows
    // the synchronized value once it has disagreed for FILT clocks in a row,
    // so shorter glitches never reach the decoder.
    for (genvar ch = 0; ch < 2; ch++) begin : g_filter
        logic [CW-1:0] fcnt;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                fcnt     <= '0;
                ab_f[ch] <= 1'b0;
            end else if (ab_s[ch] != ab_f[ch]) begin
                if (fcnt == CW'(FILT - 1)) begin
                    ab_f[ch] <= ab_s[ch];
                    fcnt     <= '0;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
            end else begin
                fcnt <= '0;
            end
        end
    end

    assign dec_ab = ab_f;
`else
    localparam int PRIME_CYC = 3;

    assign dec_ab = ab_s;
`endif

    localparam int PCW = (PRIME_CYC > 1) ? $clog2(PRIME_CYC) : 1;

    state_t         state;
    state_t         state_next;
    logic [PCW-1:0] prime_cnt;
    logic [PCW-1:0] prime_cnt_next;

    logic [1:0]     phase;
    logic [1:0]     phase_next;
    logic [n-1:0]   q_next;
    logic           step_next;
    logic           up_next;
    logic           err_next;
    logic           wrap_next;
    logic           fwd;
    logic           rev;
    logic           both;

    // Priming state register. The synchronizer (and filter) still hold reset
    // zeros right after release, so priming lasts until that pipeline has
    // flushed; otherwise inputs sitting at 11 would look like a double
    // transition on the first decode.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= PRIME;
            prime_cnt <= '0;
        end else begin
            state     <= state_next;
            prime_cnt <= prime_cnt_next;
        end
    end

    // Next-state logic: stay in PRIME for PRIME_CYC clocks, then run forever.
    always_comb begin
        state_next     = state;
        prime_cnt_next = prime_cnt;
        if (state == PRIME) begin
            if (prime_cnt == PCW'(PRIME_CYC - 1)) begin
                state_next = RUN;
            end else begin
                prime_cnt_next = prime_cnt + 1'b1;
            end
        end
    end

    // Transition classification against the last accepted phase.
    // Up sequence on {a,b}: 00 -> 01 -> 11 -> 10 -> 00; reverse order is down.
    always_comb begin
        fwd  = 1'b0;
        rev  = 1'b0;
        both = ((phase ^ dec_ab) == 2'b11);
        case ({phase, dec_ab})
            4'b0001, 4'b0111, 4'b1110, 4'b1000: fwd = 1'b1;
            4'b0010, 4'b1011, 4'b1101, 4'b0100: rev = 1'b1;
            default: ;
        endcase
    end

    // Output logic: the phase register always follows the decoded inputs,
    // which also resynchronises after an error or while disabled. Counting,
    // direction and pulses happen only when running and enabled; clr then
    // forces Q to zero and suppresses wrap without hiding step/up/err.
    always_comb begin
        phase_next = dec_ab;
        q_next     = Q;
        step_next  = 1'b0;
        up_next    = up;
        err_next   = 1'b0;
        wrap_next  = 1'b0;
        if (state == RUN && en) begin
            err_next = both;
            if (fwd) begin
                step_next = 1'b1;
                up_next   = 1'b1;
                wrap_next = (Q == '1);
                q_next    = Q + 1'b1;
            end else if (rev) begin
                step_next = 1'b1;
                up_next   = 1'b0;
                wrap_next = (Q == '0);
                q_next    = Q - 1'b1;
            end
        end
        if (clr) begin
            q_next    = '0;
            wrap_next = 1'b0;
        end
    end

    // Registered outputs and phase memory.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase <= 2'b00;
            Q     <= '0;
            step  <= 1'b0;
            up    <= 1'b1;
            err   <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            phase <= phase_next;
            Q     <= q_next;
            step  <= step_next;
            up    <= up_next;
            err   <= err_next;
            wrap  <= wrap_next;
        end
    end

endmodule
